hazard_unit: RTL and testbench

- Hazard unit for the five-stage pipeline. It consumes the controller's decode-stage control outputs and its pipelined status (PCSrcE, RegWriteM, RegWriteW).
- Keeps its own shadow pipeline of register addresses and write-enables across stages E, M and W. From that it generates operand forwarding selects, load-use stalls and branch/jump flushes.
- Cross-checks its shadow write-enables against the controller's pipelined RegWrite bits.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_unit_sat_counter.sv | 24 ++
 rtl/hazard_unit.sv | 136 +++++++++++++
 tb/tb_hazard_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit slice.
// - fwd_e   : operand forwarding select encoding (register file, W result, M ALU result)
// - RES_LOAD: ResultSrc value that marks a load in decode
// - REG_ZERO: architectural zero register x0
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the debug event counters.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset (clears count)
//   inc   - count one event on this edge
//   count - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage pipeline.
// Tracks a shadow copy of register addresses and write-enables through E, M
// and W, and from it produces forwarding selects, load-use stalls and
// branch/jump flushes. Shadow write-enables are cross-checked against the
// controller's pipelined RegWrite bits; stall and flush events are counted.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   Rs1D, Rs2D, RdD         - register fields of the instruction in D
//   RegWriteD, ResultSrcD   - controller decode controls (ResultSrcD 01 = load)
//   PCSrcE                  - taken branch/jump resolved in E
//   RegWriteM, RegWriteW    - controller pipelined RegWrite (cross-check only)
//   StallF, StallD          - hold PC / D register on load-use
//   FlushD, FlushE          - clear D / E pipeline registers
//   ForwardAE, ForwardBE    - operand selects: 00 RF, 10 ALUResultM, 01 ResultW
//   StallCnt, FlushCnt      - saturating event counters
//   MismatchErr             - sticky shadow/controller RegWrite disagreement
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic              MismatchErr
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, LoadE, RegWriteSM, RegWriteSW;
  logic              lwStall, pcSrcG;
  fwd_e              fwdA, fwdB;

  // PCSrcE comes from outside; gate it so nothing leaks out while in reset.
  assign pcSrcG  = PCSrcE & reset;

  // Conservative: any source match counts, even if D does not read it.
  assign lwStall = reset & LoadE & (RdE != ZERO) & ((Rs1D == RdE) | (Rs2D == RdE));

  assign StallF  = lwStall;
  assign StallD  = lwStall;
  assign FlushD  = pcSrcG;
  assign FlushE  = lwStall | pcSrcG;

  // M is younger than W, so it must win when both write the same register.
  always_comb begin
    fwdA = FWD_RF;
    if (RegWriteSM && (RdM != ZERO) && (Rs1E == RdM)) begin
      fwdA = FWD_M;
    end else if (RegWriteSW && (RdW != ZERO) && (Rs1E == RdW)) begin
      fwdA = FWD_W;
    end
  end

  always_comb begin
    fwdB = FWD_RF;
    if (RegWriteSM && (RdM != ZERO) && (Rs2E == RdM)) begin
      fwdB = FWD_M;
    end else if (RegWriteSW && (RdW != ZERO) && (Rs2E == RdW)) begin
      fwdB = FWD_W;
    end
  end

  assign ForwardAE = fwdA;
  assign ForwardBE = fwdB;

  // Shadow pipeline. E is never held: on a load-use stall the controller
  // inserts a bubble into E, which the FlushE clear reproduces here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      LoadE       <= 1'b0;
      RdM         <= '0;
      RegWriteSM  <= 1'b0;
      RdW         <= '0;
      RegWriteSW  <= 1'b0;
      MismatchErr <= 1'b0;
    end else begin
      if (FlushE) begin
        Rs1E      <= '0;
        Rs2E      <= '0;
        RdE       <= '0;
        RegWriteE <= 1'b0;
        LoadE     <= 1'b0;
      end else begin
        Rs1E      <= Rs1D;
        Rs2E      <= Rs2D;
        RdE       <= RdD;
        RegWriteE <= RegWriteD;
        LoadE     <= (ResultSrcD == RES_LOAD);
      end
      RdM        <= RdE;
      RegWriteSM <= RegWriteE;
      RdW        <= RdM;
      RegWriteSW <= RegWriteSM;
      if ((RegWriteSM != RegWriteM) || (RegWriteSW != RegWriteW)) begin
        MismatchErr <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lwStall),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pcSrcG),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. A second instance with 2-bit counters runs
// on the same stimulus to observe saturation. Each cycle the stimulus pushes
// the expected output vector; a monitor pops and compares on the falling edge.
// Vector layout: {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,MismatchErr,
//                 StallCnt[15:0],FlushCnt[15:0],StallCnt2[1:0],FlushCnt2[1:0]}
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE, RegWriteM, RegWriteW;

  logic        StallF, StallD, FlushD, FlushE, MismatchErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt, FlushCnt;

  logic        StallF2, StallD2, FlushD2, FlushE2, MismatchErr2;
  logic [1:0]  ForwardAE2, ForwardBE2;
  logic [1:0]  StallCnt2, FlushCnt2;

  hazard_unit dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .MismatchErr(MismatchErr)
  );

  hazard_unit #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF2), .StallD(StallD2), .FlushD(FlushD2), .FlushE(FlushE2),
    .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
    .StallCnt(StallCnt2), .FlushCnt(FlushCnt2), .MismatchErr(MismatchErr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    logic [44:0] v;
  } exp_t;

  exp_t q[$];
  int   passCnt = 0;
  int   totalCnt = 0;

  // Controller-side pipeline model (drives RegWriteM/W) and expected counters.
  logic cE = 1'b0, cM = 1'b0, cW = 1'b0;
  int   sCnt = 0, fCnt = 0;
  logic misE = 1'b0;
  logic prevRst = 1'b0, prevStall = 1'b0, prevPc = 1'b0, prevFlip = 1'b0, prevRw = 1'b0;

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  task automatic step(input string nm, input logic rstN,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] rsrc, input logic pc, input logic flip,
                      input logic eStall, input logic [1:0] eA, input logic [1:0] eB);
    exp_t e;
    @(posedge clk);
    if (prevRst) begin
      if (prevStall) sCnt++;
      if (prevPc) fCnt++;
      if (prevFlip) misE = 1'b1;
      cW = cM;
      cM = cE;
      cE = (prevStall | prevPc) ? 1'b0 : prevRw;
    end
    #1;
    reset      = rstN;
    Rs1D       = rs1;
    Rs2D       = rs2;
    RdD        = rd;
    RegWriteD  = rw;
    ResultSrcD = rsrc;
    PCSrcE     = pc;
    if (!rstN) begin
      sCnt = 0; fCnt = 0; misE = 1'b0;
      cE = 1'b0; cM = 1'b0; cW = 1'b0;
    end
    RegWriteM = cM ^ (flip & rstN);
    RegWriteW = cW;
    e.nm = nm;
    if (!rstN)
      e.v = '0;
    else
      e.v = {eStall, eStall, pc, eStall | pc, eA, eB, misE,
             sCnt[15:0], fCnt[15:0], sat2(sCnt), sat2(fCnt)};
    q.push_back(e);
    prevRst   = rstN;
    prevStall = rstN & eStall;
    prevPc    = rstN & pc;
    prevFlip  = rstN & flip;
    prevRw    = rw;
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    logic [44:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, MismatchErr,
               StallCnt, FlushCnt, StallCnt2, FlushCnt2};
        totalCnt++;
        if (act === e.v) passCnt++;
        else $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Rs1D = 5'd5; Rs2D = 5'd5; RdD = 5'd5; RegWriteD = 1'b1;
    ResultSrcD = 2'b01; PCSrcE = 1'b1; RegWriteM = 1'b0; RegWriteW = 1'b0;

    //    name        rstN rs1 rs2 rd  rw rsrc  pc flip  stall fwdA   fwdB
    step("rst_a",     0, 5, 5, 5, 1, 2'b01, 1, 0,   0, 2'b00, 2'b00);
    step("rst_b",     0, 5, 5, 5, 1, 2'b00, 1, 0,   0, 2'b00, 2'b00);
    step("release",   1, 0, 0, 0, 0, 2'b00, 1, 0,   0, 2'b00, 2'b00);
    step("post_rel",  1, 1, 2, 5, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("dep_issue", 1, 5, 7, 6, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("fwd_m",     1, 5, 9, 8, 1, 2'b00, 0, 0,   0, 2'b10, 2'b00);
    step("fwd_w",     1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b01, 2'b00);
    step("x5_first",  1, 1, 2, 5, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("x5_second", 1, 3, 4, 5, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("x5_cons",   1, 5, 5,10, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("m_beats_w", 1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b10, 2'b10);
    step("lw_x5",     1, 2, 0, 5, 1, 2'b01, 0, 0,   0, 2'b00, 2'b00);
    step("lw_use",    1, 0, 5, 6, 1, 2'b00, 0, 0,   1, 2'b00, 2'b00);
    step("lw_bubble", 1, 0, 5, 6, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("lw_fwd_w",  1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b01);
    step("lw_x0",     1, 2, 0, 0, 1, 2'b01, 0, 0,   0, 2'b00, 2'b00);
    step("x0_nostall",1, 0, 0, 1, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("x0_nofwd",  1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("lw_x7",     1, 3, 0, 7, 1, 2'b01, 0, 0,   0, 2'b00, 2'b00);
    step("stall_pc",  1, 7, 0, 8, 1, 2'b00, 1, 0,   1, 2'b00, 2'b00);
    step("after_both",1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("mis_inject",1, 0, 0, 0, 0, 2'b00, 0, 1,   0, 2'b00, 2'b00);
    step("mis_set",   1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("mis_sticky",1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("sat_lw",  1, 2, 0, 5, 1, 2'b01, 0, 0,   0, 2'b00, 2'b00);
      step("sat_use", 1, 0, 5, 6, 1, 2'b00, 0, 0,   1, 2'b00, 2'b00);
      step("sat_hold",1, 0, 5, 6, 1, 2'b00, 0, 0,   0, 2'b00, 2'b00);
      step("sat_fwd", 1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b01);
    end
    step("sat_cnt",   1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("mr_lw",     1, 2, 0, 5, 1, 2'b01, 0, 0,   0, 2'b00, 2'b00);
    step("mr_use",    1, 0, 5, 6, 1, 2'b00, 0, 0,   1, 2'b00, 2'b00);
    step("mr_reset",  0, 0, 5, 6, 1, 2'b00, 1, 0,   0, 2'b00, 2'b00);
    step("mr_release",1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);
    step("mr_idle",   1, 0, 0, 0, 0, 2'b00, 0, 0,   0, 2'b00, 2'b00);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      totalCnt++;
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
